// File: rtl/fetch_stage_pkg.sv
// Shared constants, encodings and types for the instruction-fetch stage.
// Holds the reset/handler addresses, legal fetch window and npc_sel codes.
package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IM_LO      = 32'h0000_3000;
    localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
    } fd_reg_t;

    // Misaligned or outside the instruction memory window.
    function automatic logic fetch_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
// Read data is expected back in the same cycle the address is presented.
interface fetch_stage_if;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;

    modport master (output i_inst_addr, input  i_inst_rdata);
    modport slave  (input  i_inst_addr, output i_inst_rdata);
endinterface

// File: rtl/fetch_stage_npc.sv
// Next-PC selection: sequential, branch, j/jal and jr/jalr targets.
// Purely combinational; redirect priority (req, stall, eret) lives in the top.
module fetch_stage_npc
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] d_pc,
    input  logic [1:0]  npc_sel,
    input  logic [15:0] d_imm16,
    input  logic [25:0] d_imm26,
    input  logic [31:0] d_rs_val,
    output logic [31:0] npc
);

    logic [31:0] br_target;
    logic [31:0] j_target;

    // Branch and jump targets are relative to the control instruction in D,
    // not to the delay slot currently being fetched.
    assign br_target = d_pc + 32'd4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
    assign j_target  = {d_pc[31:28], d_imm26, 2'b00};

    always_comb begin
        npc = pc + 32'd4;
        case (npc_sel_e'(npc_sel))
            NPC_BR:  npc = br_target;
            NPC_J:   npc = j_target;
            NPC_JR:  npc = d_rs_val;
            default: npc = pc + 32'd4;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC priority and the F/D pipeline register.
// Out-of-window or misaligned fetches enter D as a nop tagged with AdEL.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 req,
    input  logic                 d_eret,
    input  logic [31:0]          epc,
    input  logic [1:0]           npc_sel,
    input  logic                 d_is_ctrl,
    input  logic [15:0]          d_imm16,
    input  logic [25:0]          d_imm26,
    input  logic [31:0]          d_rs_val,
    output logic [31:0]          F_pc,
    output logic [31:0]          D_instr,
    output logic [31:0]          D_pc,
    output logic                 D_bd,
    output logic [4:0]           D_exc
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    fd_reg_t     fd_reg;
    fd_reg_t     fd_next;
    logic        fetch_bad;

    fetch_stage_npc u_npc (
        .pc       (pc_reg),
        .d_pc     (fd_reg.pc),
        .npc_sel  (npc_sel),
        .d_imm16  (d_imm16),
        .d_imm26  (d_imm26),
        .d_rs_val (d_rs_val),
        .npc      (pc_next)
    );

    assign fetch_bad = fetch_fault(pc_reg);

    always_comb begin
        fd_next.instr = fetch_bad ? 32'd0 : imem.i_inst_rdata;
        fd_next.pc    = pc_reg;
        fd_next.bd    = d_is_ctrl;
        fd_next.exc   = fetch_bad ? EXC_ADEL : EXC_NONE;
    end

    // req beats stall; eret discards the word fetched alongside it (no delay slot).
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= PC_RESET;
            fd_reg <= '{instr: 32'd0, pc: PC_RESET, bd: 1'b0, exc: EXC_NONE};
        end else if (req) begin
            pc_reg <= HANDLER_PC;
            fd_reg <= '{instr: 32'd0, pc: HANDLER_PC, bd: 1'b0, exc: EXC_NONE};
        end else if (!stall) begin
            if (d_eret) begin
                pc_reg <= epc;
                fd_reg <= '{instr: 32'd0, pc: epc, bd: 1'b0, exc: EXC_NONE};
            end else begin
                pc_reg <= pc_next;
                fd_reg <= fd_next;
            end
        end
    end

    assign imem.i_inst_addr = pc_reg;
    assign F_pc             = pc_reg;
    assign D_instr          = fd_reg.instr;
    assign D_pc             = fd_reg.pc;
    assign D_bd             = fd_reg.bd;
    assign D_exc            = fd_reg.exc;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized traffic,
// all compared against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, req, d_eret, d_is_ctrl;
    logic [31:0] epc, d_rs_val;
    logic [1:0]  npc_sel;
    logic [15:0] d_imm16;
    logic [25:0] d_imm26;
    logic [31:0] F_pc, D_instr, D_pc;
    logic        D_bd;
    logic [4:0]  D_exc;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:16383];

    // Reference model state
    logic [31:0] m_pc, m_instr, m_dpc;
    logic        m_bd;
    logic [4:0]  m_exc;

    fetch_stage_if bus ();
    assign bus.i_inst_rdata = mem[bus.i_inst_addr[15:2]];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .imem      (bus.master),
        .stall     (stall),
        .req       (req),
        .d_eret    (d_eret),
        .epc       (epc),
        .npc_sel   (npc_sel),
        .d_is_ctrl (d_is_ctrl),
        .d_imm16   (d_imm16),
        .d_imm26   (d_imm26),
        .d_rs_val  (d_rs_val),
        .F_pc      (F_pc),
        .D_instr   (D_instr),
        .D_pc      (D_pc),
        .D_bd      (D_bd),
        .D_exc     (D_exc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; req = 1'b0; d_eret = 1'b0; d_is_ctrl = 1'b0;
        epc = 32'd0; npc_sel = 2'd0; d_imm16 = 16'd0; d_imm26 = 26'd0; d_rs_val = 32'd0;
    endtask

    // Advance one clock: compute the model's next state from the fetch rules,
    // let the DUT take the edge, then compare everything visible.
    task automatic step(input string tag);
        logic [31:0] n_pc, n_instr, n_dpc;
        logic        n_bd;
        logic [4:0]  n_exc;
        logic        bad;
        int          off;
        n_pc = m_pc; n_instr = m_instr; n_dpc = m_dpc; n_bd = m_bd; n_exc = m_exc;
        if (reset) begin
            n_pc = 32'h3000; n_instr = 0; n_dpc = 32'h3000; n_bd = 0; n_exc = 0;
        end else if (req) begin
            n_pc = 32'h4180; n_instr = 0; n_dpc = 32'h4180; n_bd = 0; n_exc = 0;
        end else if (stall) begin
            // everything holds
        end else if (d_eret) begin
            n_pc = epc; n_instr = 0; n_dpc = epc; n_bd = 0; n_exc = 0;
        end else begin
            bad     = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc > 32'h6FFC);
            n_instr = bad ? 32'd0 : mem[m_pc[15:2]];
            n_dpc   = m_pc;
            n_bd    = d_is_ctrl;
            n_exc   = bad ? 5'd4 : 5'd0;
            off     = int'($signed(d_imm16));
            case (npc_sel)
                2'd1:    n_pc = m_dpc + 32'd4 + 32'(off * 4);
                2'd2:    n_pc = (m_dpc & 32'hF000_0000) | (32'(d_imm26) * 4);
                2'd3:    n_pc = d_rs_val;
                default: n_pc = m_pc + 32'd4;
            endcase
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_dpc = n_dpc; m_bd = n_bd; m_exc = n_exc;
        chk({tag, ".addr"}, bus.i_inst_addr, m_pc);
        chk({tag, ".F_pc"}, F_pc, m_pc);
        chk({tag, ".D_instr"}, D_instr, m_instr);
        chk({tag, ".D_pc"}, D_pc, m_dpc);
        chk({tag, ".D_bd"}, {31'd0, D_bd}, {31'd0, m_bd});
        chk({tag, ".D_exc"}, {27'd0, D_exc}, {27'd0, m_exc});
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[32'h3000 >> 2] = 32'h3401_0001;
        m_pc = 0; m_instr = 0; m_dpc = 0; m_bd = 0; m_exc = 0;
        idle_inputs();

        // 1: reset then first fetch
        reset = 1'b1;
        step("reset");
        chk("reset.addr_const", bus.i_inst_addr, 32'h3000);
        reset = 1'b0;
        step("first");
        chk("first.D_instr_const", D_instr, 32'h3401_0001);
        chk("first.pc_const", F_pc, 32'h3004);

        // 2: beq taken in D at 0x3008, imm16 = 0xFFFE
        step("seq1");
        step("seq2");
        chk("beq.D_pc_const", D_pc, 32'h3008);
        npc_sel = 2'd1; d_imm16 = 16'hFFFE; d_is_ctrl = 1'b1;
        step("beq");
        chk("beq.slot_pc", D_pc, 32'h300C);
        chk("beq.slot_bd", {31'd0, D_bd}, 32'd1);
        chk("beq.target", F_pc, 32'h3004);

        // 3: stall for three cycles with a branch pending
        d_imm16 = 16'h0004; stall = 1'b1;
        for (int i = 0; i < 3; i++) step("stall");
        chk("stall.pc_const", F_pc, 32'h3004);
        chk("stall.dpc_const", D_pc, 32'h300C);
        stall = 1'b0;
        step("stall_release");
        chk("stall.redirect", F_pc, 32'h3020);
        idle_inputs();

        // 4: req together with stall at PC 0x3010
        npc_sel = 2'd2; d_imm26 = 26'(32'h3010 >> 2); d_is_ctrl = 1'b1;
        step("j3010");
        chk("j.pc_const", F_pc, 32'h3010);
        idle_inputs();
        req = 1'b1; stall = 1'b1;
        step("req_stall");
        chk("req.pc_const", F_pc, 32'h4180);
        chk("req.dpc_const", D_pc, 32'h4180);
        idle_inputs();
        step("handler");

        // 5: eret to 0x3020
        d_eret = 1'b1; epc = 32'h3020;
        step("eret");
        chk("eret.pc_const", F_pc, 32'h3020);
        chk("eret.bubble", D_instr, 32'd0);
        idle_inputs();
        step("after_eret");

        // 6: jr to misaligned and out-of-window targets, plus window edges
        npc_sel = 2'd3; d_rs_val = 32'h3002;
        step("jr3002");
        idle_inputs();
        step("fetch3002");
        chk("adel_mis.exc", {27'd0, D_exc}, 32'd4);
        chk("adel_mis.instr", D_instr, 32'd0);
        npc_sel = 2'd3; d_rs_val = 32'h7000;
        step("jr7000");
        idle_inputs();
        step("fetch7000");
        chk("adel_hi.exc", {27'd0, D_exc}, 32'd4);
        npc_sel = 2'd3; d_rs_val = 32'h6FFC;
        step("jr6ffc");
        idle_inputs();
        step("fetch6ffc");
        chk("edge_hi.exc", {27'd0, D_exc}, 32'd0);
        npc_sel = 2'd3; d_rs_val = 32'h2FFC;
        step("jr2ffc");
        idle_inputs();
        step("fetch2ffc");
        chk("adel_lo.exc", {27'd0, D_exc}, 32'd4);

        // reset during a stall with a jr pending
        stall = 1'b1; npc_sel = 2'd3; d_rs_val = 32'h5000; reset = 1'b1;
        step("reset_mid");
        chk("reset_mid.pc", F_pc, 32'h3000);
        idle_inputs();

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            req       = ($urandom_range(0, 24) == 0);
            stall     = ($urandom_range(0, 5) == 0);
            d_eret    = ($urandom_range(0, 19) == 0);
            epc       = 32'h3000 + 4 * $urandom_range(0, 32'hFFF);
            npc_sel   = 2'($urandom_range(0, 3));
            d_is_ctrl = (npc_sel != 2'd0) || ($urandom_range(0, 7) == 0);
            d_imm16   = 16'($urandom_range(0, 127)) - 16'd64;
            d_imm26   = 26'((32'h3000 + 4 * $urandom_range(0, 32'hFFF)) >> 2);
            d_rs_val  = 32'h2FF0 + $urandom_range(0, 32'h4020);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
